// File: rtl/decoder_pipe.sv
// Registered binary-to-one-hot/thermometer decoder behind a 2-entry skid buffer.
// Optional saturating out-of-range counter: define DECODER_PIPE_ERR_CNT_EN.
module decoder_pipe #(
    parameter int OUT_WIDTH     = 3,
    parameter int MODE          = 0,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  logic [((OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1)-1:0] in,
    output logic out_valid,
    input  logic out_ready,
    output logic [OUT_WIDTH-1:0] out,
    output logic out_err
`ifdef DECODER_PIPE_ERR_CNT_EN
    ,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
`endif
);

    localparam int IN_WIDTH = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                 r_in_ready;
    logic [OUT_WIDTH-1:0] r_reg_data;
    logic                 r_reg_err;
    logic [OUT_WIDTH-1:0] r_skid_data;
    logic                 r_skid_err;

    logic [31:0]          w_code;
    logic [OUT_WIDTH-1:0] w_dec;
    logic                 w_err;
    logic                 w_accept;
    logic                 w_xfer;
    logic                 w_load_reg;
    logic                 w_load_skid;
    logic                 w_skid_to_reg;

    assign w_code = 32'(in);
    assign w_err  = (w_code >= $unsigned(OUT_WIDTH));

    always_comb begin
        w_dec = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            if (MODE == 1) begin
                w_dec[i] = (w_code >= $unsigned(i)) && !w_err;
            end else begin
                w_dec[i] = (w_code == $unsigned(i));
            end
        end
    end

    assign out_valid = (r_state != ST_EMPTY);
    assign in_ready  = r_in_ready;
    assign out       = r_reg_data;
    assign out_err   = r_reg_err;

    assign w_accept = in_valid & r_in_ready;
    assign w_xfer   = out_valid & out_ready;

    always_comb begin
        w_next        = r_state;
        w_load_reg    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_reg = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_next     = ST_ONE;
                    w_load_reg = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_xfer) begin
                    w_load_reg = 1'b1;
                end else if (w_accept) begin
                    w_next      = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_xfer) begin
                    w_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_xfer) begin
                    w_next        = ST_ONE;
                    w_skid_to_reg = 1'b1;
                end
            end
            default: begin
                w_next = ST_EMPTY;
            end
        endcase
    end

    // in_ready is registered from the next state, so it never sees out_ready
    // combinationally; it is low only while the skid entry will be occupied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_reg_data  <= '0;
            r_reg_err   <= 1'b0;
            r_skid_data <= '0;
            r_skid_err  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != ST_TWO);
            if (w_load_reg) begin
                r_reg_data <= w_dec;
                r_reg_err  <= w_err;
            end else if (w_skid_to_reg) begin
                r_reg_data <= r_skid_data;
                r_reg_err  <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid_data <= w_dec;
                r_skid_err  <= w_err;
            end
        end
    end

`ifdef DECODER_PIPE_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    localparam int lp_unused_err_cnt_w = ERR_CNT_WIDTH;
`endif

    localparam int lp_unused_in_w = IN_WIDTH;

endmodule

// File: tb/tb_decoder_pipe.sv
// Bench for decoder_pipe: three configurations share one handshake stream,
// checked against a table of expected words through a scoreboard queue.
module tb_decoder_pipe;

    typedef struct {
        logic [2:0] ea;
        logic       era;
        logic [4:0] eb;
        logic       erb;
        logic [4:0] ec;
        logic       erc;
    } rec_t;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       d_valid = 1'b0;
    logic       d_ordy  = 1'b0;
    logic [2:0] d_code  = 3'd0;

    logic       a_in_ready, a_out_valid, a_err;
    logic [2:0] a_out;
    logic       b_in_ready, b_out_valid, b_err;
    logic [4:0] b_out;
    logic       c_in_ready, c_out_valid, c_err;
    logic [4:0] c_out;
`ifdef DECODER_PIPE_ERR_CNT_EN
    logic [7:0] a_err_cnt;
    logic [7:0] b_err_cnt;
    logic [1:0] c_err_cnt;
`endif

    rec_t tbl[8];
    rec_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   m_cnt   = 0;
    logic m_rdy   = 1'b0;
    int   ma = 0, mb = 0, mc = 0;
    logic last_acc = 1'b0;

    always #5 clk = ~clk;

    decoder_pipe #(.OUT_WIDTH(3), .MODE(0)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(d_valid), .in_ready(a_in_ready), .in(d_code[1:0]),
        .out_valid(a_out_valid), .out_ready(d_ordy),
        .out(a_out), .out_err(a_err)
`ifdef DECODER_PIPE_ERR_CNT_EN
        , .err_cnt(a_err_cnt)
`endif
    );

    decoder_pipe #(.OUT_WIDTH(5), .MODE(1)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(d_valid), .in_ready(b_in_ready), .in(d_code),
        .out_valid(b_out_valid), .out_ready(d_ordy),
        .out(b_out), .out_err(b_err)
`ifdef DECODER_PIPE_ERR_CNT_EN
        , .err_cnt(b_err_cnt)
`endif
    );

    decoder_pipe #(.OUT_WIDTH(5), .MODE(0), .ERR_CNT_WIDTH(2)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(d_valid), .in_ready(c_in_ready), .in(d_code),
        .out_valid(c_out_valid), .out_ready(d_ordy),
        .out(c_out), .out_err(c_err)
`ifdef DECODER_PIPE_ERR_CNT_EN
        , .err_cnt(c_err_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic cmp_all();
        logic [31:0] v;
        v = (m_cnt != 0) ? 32'd1 : 32'd0;
        chk("a_in_ready", 32'(a_in_ready), 32'(m_rdy));
        chk("b_in_ready", 32'(b_in_ready), 32'(m_rdy));
        chk("c_in_ready", 32'(c_in_ready), 32'(m_rdy));
        chk("a_out_valid", 32'(a_out_valid), v);
        chk("b_out_valid", 32'(b_out_valid), v);
        chk("c_out_valid", 32'(c_out_valid), v);
        if (m_cnt != 0 && q.size() != 0) begin
            chk("a_out", 32'(a_out), 32'(q[0].ea));
            chk("a_out_err", 32'(a_err), 32'(q[0].era));
            chk("b_out", 32'(b_out), 32'(q[0].eb));
            chk("b_out_err", 32'(b_err), 32'(q[0].erb));
            chk("c_out", 32'(c_out), 32'(q[0].ec));
            chk("c_out_err", 32'(c_err), 32'(q[0].erc));
        end
`ifdef DECODER_PIPE_ERR_CNT_EN
        chk("a_err_cnt", 32'(a_err_cnt), 32'(ma));
        chk("b_err_cnt", 32'(b_err_cnt), 32'(mb));
        chk("c_err_cnt", 32'(c_err_cnt), 32'(mc));
`endif
    endtask

    task automatic drv(input logic v, input int c, input logic r);
        d_valid = v;
        d_code  = 3'(c);
        d_ordy  = r;
    endtask

    task automatic tick();
        logic acc;
        logic xfer;
        rec_t r;
        #1;
        chk("in_ready_comb", 32'({a_in_ready, b_in_ready, c_in_ready}),
            32'({3{m_rdy}}));
        acc  = d_valid && m_rdy;
        xfer = (m_cnt != 0) && d_ordy;
        if (xfer && q.size() != 0) r = q.pop_front();
        if (acc) begin
            r = tbl[d_code];
            q.push_back(r);
            if (r.era && ma < 255) ma++;
            if (r.erb && mb < 255) mb++;
            if (r.erc && mc < 3) mc++;
        end
        m_cnt    = m_cnt + int'(acc) - int'(xfer);
        m_rdy    = (m_cnt < 2);
        last_acc = acc;
        @(posedge clk);
        @(negedge clk);
        cmp_all();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        d_valid = 1'b0;
        #1;
        chk("rst_out_valid", 32'({a_out_valid, b_out_valid, c_out_valid}), 0);
        chk("rst_out", 32'({a_out, b_out, c_out}), 0);
        chk("rst_out_err", 32'({a_err, b_err, c_err}), 0);
        chk("rst_in_ready", 32'({a_in_ready, b_in_ready, c_in_ready}), 0);
`ifdef DECODER_PIPE_ERR_CNT_EN
        chk("rst_err_cnt", 32'({a_err_cnt, b_err_cnt, c_err_cnt}), 0);
`endif
        q.delete();
        m_cnt = 0;
        m_rdy = 1'b0;
        ma = 0;
        mb = 0;
        mc = 0;
        @(posedge clk);
        @(negedge clk);
        cmp_all();
        rst = 1'b0;
        tick();
    endtask

    task automatic drain();
        drv(1'b0, 0, 1'b1);
        repeat (4) tick();
    endtask

    initial begin
        int sw[7];
        int ec[6];
        int ee[6];
        int n_acc;

        // a: 3-wide one-hot on code[1:0]; b: 5-wide thermometer; c: 5-wide one-hot
        tbl[0] = '{3'b001, 1'b0, 5'b00001, 1'b0, 5'b00001, 1'b0};
        tbl[1] = '{3'b010, 1'b0, 5'b00011, 1'b0, 5'b00010, 1'b0};
        tbl[2] = '{3'b100, 1'b0, 5'b00111, 1'b0, 5'b00100, 1'b0};
        tbl[3] = '{3'b000, 1'b1, 5'b01111, 1'b0, 5'b01000, 1'b0};
        tbl[4] = '{3'b001, 1'b0, 5'b11111, 1'b0, 5'b10000, 1'b0};
        tbl[5] = '{3'b010, 1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1};
        tbl[6] = '{3'b100, 1'b0, 5'b00000, 1'b1, 5'b00000, 1'b1};
        tbl[7] = '{3'b000, 1'b1, 5'b00000, 1'b1, 5'b00000, 1'b1};
        sw = '{0, 1, 2, 3, 4, 5, 7};
        ec = '{5, 1, 6, 7, 5, 7};
        ee = '{1, 1, 2, 3, 3, 3};

        @(negedge clk);
        do_reset();
        chk("ready_after_release", 32'(a_in_ready), 1);

        drv(1'b1, 1, 1'b0);
        tick();
        drv(1'b1, 2, 1'b0);
        tick();
        chk("midflight_full", 32'(a_in_ready), 0);
        drv(1'b0, 0, 1'b0);
        do_reset();
        chk("midflight_ready", 32'(a_in_ready), 1);
        drv(1'b1, 0, 1'b1);
        tick();
        chk("post_rst_out", 32'(a_out), 32'(3'b001));
        drain();

        for (int i = 0; i < 7; i++) begin
            drv(1'b1, sw[i], 1'b1);
            tick();
        end
        drain();

        drv(1'b1, 1, 1'b0);
        tick();
        drv(1'b1, 3, 1'b0);
        tick();
        chk("bp_full", 32'(c_in_ready), 0);
        drv(1'b1, 4, 1'b0);
        repeat (3) tick();
        chk("bp_hold_out", 32'(c_out), 32'(5'b00010));
        drv(1'b1, 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (last_acc) break;
        end
        drain();

        n_acc = 0;
        for (int cyc = 0; cyc < 20000 && n_acc < 1000; cyc++) begin
            drv($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                $urandom_range(0, 2) != 0);
            tick();
            if (last_acc) n_acc++;
        end
        drain();

`ifdef DECODER_PIPE_ERR_CNT_EN
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drv(1'b1, ec[i], 1'b1);
            tick();
            chk("err_cnt_seq", 32'(c_err_cnt), 32'(ee[i]));
        end
        drain();
        do_reset();
        chk("err_cnt_clr", 32'(c_err_cnt), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decoder_pipe.md
Name: decoder_pipe

Overview:
- Registered, parametrised successor to the combinational one-hot decoder.
- Decodes a binary code into a one-hot or thermometer word. Out-of-range codes produce an all-zero word and an error flag.
- Sits between a valid/ready producer and consumer. A 2-entry skid buffer sustains one code per clock under backpressure, with no combinational ready path.

Parameters:
- OUT_WIDTH, 3, number of output bits (>= 1).
- MODE, 0, 0 = one-hot, 1 = thermometer.
- IN_WIDTH, (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1, input code width; localparam-derived, not overridable.
- ERR_CNT_WIDTH, 8, error counter width (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input code valid.
- in_ready  out  1  block can accept a code.
- in  in  IN_WIDTH  binary code.
- out_valid  out  1  decoded word valid.
- out_ready  in  1  consumer accepts word.
- out  out  OUT_WIDTH  decoded word.
- out_err  out  1  word came from an out-of-range code (in >= OUT_WIDTH).
- err_cnt  out  ERR_CNT_WIDTH  saturating out-of-range count (present only with the optional feature).

Behaviour:
- Reset is asynchronous, active-high. While rst = 1: out_valid = 0, out = 0, out_err = 0, in_ready = 0, err_cnt = 0, both buffer entries invalid. in_ready goes to 1 on the first clock edge after rst deasserts.
- Reset asserted mid-transfer discards all buffered words immediately; no partial output.
- Decode is combinational on `in`, applied at acceptance; only decoded words are stored.
- One-hot (MODE = 0), code c < OUT_WIDTH: out = 1 << c.
- Thermometer (MODE = 1), code c < OUT_WIDTH: out bits [c:0] = 1, rest 0. Example: c = 0 -> ...001; c = 2 -> ...111.
- Any code c >= OUT_WIDTH: out = 0, out_err = 1. The word is still delivered as a normal transfer.
- Input accept: in_valid & in_ready. Output transfer: out_valid & out_ready.
- in_ready is a register, true iff the skid entry is empty; never depends on out_ready combinationally.
- State machine (reg = head entry, skid = second entry):
  - EMPTY: out_valid = 0.
    - Accept -> ONE (reg loaded).
  - ONE: out_valid = 1.
    - Accept & transfer -> ONE (reg reloaded).
    - Accept & !transfer -> TWO (skid loaded).
    - !accept & transfer -> EMPTY.
    - Otherwise hold.
  - TWO: out_valid = 1, in_ready = 0.
    - Transfer -> ONE (skid moves to reg).
    - Otherwise hold.
- Latency: 1 clock from accept to out_valid when EMPTY. Throughput 1 word/clock when out_ready is held high.
- Order is strictly FIFO. No drops or duplicates.
- out and out_err are stable while out_valid & !out_ready.
- in_valid may drop without a handshake; the block does not need in to stay stable when in_ready = 0.

Optional Feature:
- Macro: DECODER_PIPE_ERR_CNT_EN.
- Defined:
  - err_cnt port exists.
  - Increments by 1 on each accepted out-of-range code.
  - Saturates at all-ones; never wraps.
  - Cleared only by rst.
- Undefined:
  - err_cnt port and counter logic are absent.
  - out_err behaviour is unchanged.

Test Plan:
- Reset mid-flight, OUT_WIDTH = 3, MODE = 0: accept code 1, stall out_ready = 0, accept code 2, pulse rst -> out_valid = 0 and out = 0 immediately; in_ready = 1 one clock after rst release; the first post-reset code 0 yields out = 3'b001.
- Streaming sweep, OUT_WIDTH = 3, MODE = 0, out_ready = 1: codes 0, 1, 2, 3 back-to-back -> out = 001, 010, 100, 000 on consecutive clocks starting 1 clock after the first accept; out_err = 0, 0, 0, 1; in_ready stays 1.
- Thermometer, OUT_WIDTH = 5, MODE = 1: codes 0, 2, 4, 5, 7 -> out = 00001, 00111, 11111, 00000, 00000; out_err = 1 on the last two.
- Backpressure, OUT_WIDTH = 5, MODE = 0: out_ready = 0, send codes 1, 3, 4 -> first two accepted, in_ready = 0 after the second, third held; release out_ready -> outputs 00010, 01000, 10000 in order, out held stable while stalled.
- Random valid/ready toggling, 1000 codes in [0, 7], OUT_WIDTH = 5 -> scoreboard matches every word in order; no in_ready → out_ready combinational path (in_ready changes only at clock edges).
- With DECODER_PIPE_ERR_CNT_EN, ERR_CNT_WIDTH = 2: send 5 out-of-range codes -> err_cnt = 1, 2, 3, 3, 3; in-range codes leave it unchanged; rst clears it to 0.
